// File: rtl/cdc_fifo_pkg.sv
// cdc_fifo_pkg: shared defaults and width-generic Gray/binary conversions for both FIFO controllers
package cdc_fifo_pkg;
  localparam int DEF_ADDR_W = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int MAX_W = 32;
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
    logic [MAX_W-1:0] b;
    b = '0;
    for (int i = 0; i < MAX_W; i++) b[i] = ^(g >> i);
    return b;
  endfunction
endpackage

// File: rtl/ptr_sync.sv
// ptr_sync: N-stage WIDTH-bit synchroniser with asynchronous active-low reset
module ptr_sync #(
  parameter int N = 2,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [N-1:0][WIDTH-1:0] stg;
  // shift the async input through N flops, oldest stage drives q
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stg <= '0;
    else stg <= {stg[N-2:0], d};
  assign q = stg[N-1];
endmodule

// File: rtl/fifo_write_ctrl.sv
// fifo_write_ctrl: write-side pointer, flags and overflow tracking for the dual-clock FIFO
module fifo_write_ctrl
  import cdc_fifo_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int AFULL_THRESH = 2**ADDR_W - 2
) (
  input  logic              write_clk,
  input  logic              write_rst_n,
  input  logic              write_enable_in,
  input  logic              overflow_clr,
  input  logic [ADDR_W:0]   read_addr_gray_async,
  output logic [ADDR_W-1:0] write_addr,
  output logic [ADDR_W:0]   write_addr_gray,
  output logic              write_enable_out,
  output logic              fifo_full,
  output logic              fifo_almost_full,
  output logic [ADDR_W:0]   write_level,
  output logic              overflow
);
  localparam int PW = ADDR_W + 1;
  localparam int DEPTH = 2**ADDR_W;
  if (ADDR_W < 2 || SYNC_STAGES < 2 || AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_params
    $error("fifo_write_ctrl: illegal parameters");
  end
  logic [PW-1:0] wptr, wptr_next, rptr_gray_s, rptr_s, level_next;
  ptr_sync #(.N(SYNC_STAGES), .WIDTH(PW)) u_rptr_sync (
    .clk  (write_clk),
    .rst_n(write_rst_n),
    .d    (read_addr_gray_async),
    .q    (rptr_gray_s)
  );
  assign write_enable_out = write_enable_in & ~fifo_full;
  assign write_addr = wptr[ADDR_W-1:0];
  assign wptr_next = wptr + PW'(write_enable_out);
  assign rptr_s = PW'(gray2bin(MAX_W'(rptr_gray_s)));
  assign level_next = wptr_next - rptr_s;
  // pointer, Gray copy and flags all registered from the post-accept pointer; overflow set beats clear
  always_ff @(posedge write_clk or negedge write_rst_n)
    if (!write_rst_n) begin
      wptr <= '0;
      write_addr_gray <= '0;
      fifo_full <= 1'b0;
      fifo_almost_full <= 1'b0;
      write_level <= '0;
      overflow <= 1'b0;
    end else begin
      wptr <= wptr_next;
      write_addr_gray <= PW'(bin2gray(MAX_W'(wptr_next)));
      fifo_full <= level_next == PW'(DEPTH);
      fifo_almost_full <= level_next >= PW'(AFULL_THRESH);
      write_level <= level_next;
      overflow <= (write_enable_in & fifo_full) | (overflow & ~overflow_clr);
    end
endmodule

// File: tb/tb_fifo_write_ctrl.sv
// tb_fifo_write_ctrl: randomized scoreboard bench for the FIFO write controller
module tb_fifo_write_ctrl;
  localparam int S = 2;
  localparam int DEPTH = 16;
  localparam int PMOD = 32;
  typedef struct {
    int waddr, gray, full, af, lvl, ov, weo;
  } exp_t;
  logic clk = 0, rst_n = 1, we = 0, clr = 0;
  logic [4:0] rg = '0;
  logic [3:0] waddr;
  logic [4:0] wgray, wlvl;
  logic weo, full, af, ov;
  logic we2 = 0;
  logic [3:0] rg2 = '0;
  logic [2:0] waddr2;
  logic [3:0] wgray2, wlvl2;
  logic weo2, full2, af2, ov2;
  int tests = 0, fails = 0;
  int wcnt = 0, wabs = 0, rabs = 0, full_m = 0, af_m = 0, lvl_m = 0, ov_m = 0;
  int cur_we = 0, cur_clr = 0, cur_r = 0;
  int hist[$];
  exp_t sb[$];
  always #5 clk = ~clk;
  fifo_write_ctrl u_dut (
    .write_clk(clk), .write_rst_n(rst_n), .write_enable_in(we), .overflow_clr(clr),
    .read_addr_gray_async(rg), .write_addr(waddr), .write_addr_gray(wgray),
    .write_enable_out(weo), .fifo_full(full), .fifo_almost_full(af),
    .write_level(wlvl), .overflow(ov)
  );
  fifo_write_ctrl #(.ADDR_W(3), .SYNC_STAGES(3), .AFULL_THRESH(8)) u_dut2 (
    .write_clk(clk), .write_rst_n(rst_n), .write_enable_in(we2), .overflow_clr(1'b0),
    .read_addr_gray_async(rg2), .write_addr(waddr2), .write_addr_gray(wgray2),
    .write_enable_out(weo2), .fifo_full(full2), .fifo_almost_full(af2),
    .write_level(wlvl2), .overflow(ov2)
  );
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction
  function automatic int gray_of(int n);
    return n ^ (n >> 1);
  endfunction
  function automatic void model_edge();
    int acc, rs;
    acc = (cur_we != 0 && full_m == 0) ? 1 : 0;
    ov_m = ((cur_we != 0 && full_m != 0) || (ov_m != 0 && cur_clr == 0)) ? 1 : 0;
    wcnt = (wcnt + acc) % PMOD;
    wabs += acc;
    hist.push_back(cur_r % PMOD);
    if (hist.size() > 4) void'(hist.pop_front());
    rs = hist.size() > S ? hist[hist.size() - 1 - S] : 0;
    lvl_m = (wcnt - rs + PMOD) % PMOD;
    full_m = lvl_m == DEPTH ? 1 : 0;
    af_m = lvl_m >= DEPTH - 2 ? 1 : 0;
  endfunction
  function automatic void model_reset();
    wcnt = 0; wabs = 0; rabs = 0; full_m = 0; af_m = 0; lvl_m = 0; ov_m = 0;
    cur_we = 0; cur_clr = 0; cur_r = 0;
    hist.delete();
  endfunction
  task automatic step(input int w, input int c, input int rn);
    exp_t e;
    cur_we = w; cur_clr = c; cur_r = rn;
    we = w[0]; clr = c[0]; rg = 5'(gray_of(rn % PMOD));
    e.waddr = wcnt % DEPTH; e.gray = gray_of(wcnt); e.full = full_m; e.af = af_m;
    e.lvl = lvl_m; e.ov = ov_m; e.weo = (w != 0 && full_m == 0) ? 1 : 0;
    sb.push_back(e);
    @(posedge clk); #1;
    model_edge();
  endtask
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("write_addr", 32'(waddr), e.waddr);
      chk("write_addr_gray", 32'(wgray), e.gray);
      chk("fifo_full", 32'(full), e.full);
      chk("fifo_almost_full", 32'(af), e.af);
      chk("write_level", 32'(wlvl), e.lvl);
      chk("overflow", 32'(ov), e.ov);
      chk("write_enable_out", 32'(weo), e.weo);
    end
  end
  initial begin
    int first_af, first_full, n, any_full, wrapped;
    logic [4:0] pg;
    #1 rst_n = 0; we = 1;
    #1;
    chk("rst_addr", 32'(waddr), 0);
    chk("rst_gray", 32'(wgray), 0);
    chk("rst_level", 32'({full, af, ov}), 0);
    chk("rst_wlvl", 32'(wlvl), 0);
    chk("rst_weo_passthru", 32'(weo), 1);
    chk("rst_dut2", 32'({wgray2, wlvl2, full2, af2, ov2}), 0);
    we = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    model_edge();
    first_af = 0; first_full = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1, 0, 0);
      if (af && first_af == 0) first_af = i;
      if (full && first_full == 0) first_full = i;
    end
    chk("afull_edge", first_af, 14);
    chk("full_edge", first_full, 16);
    chk("full_gray", 32'(wgray), 32'b11000);
    chk("full_addr", 32'(waddr), 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    chk("drop_ov", 32'(ov), 1);
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    chk("setwins_ov", 32'(ov), 1);
    step(0, 1, 0);
    step(0, 0, 1);
    n = 1;
    while (full && n < 10) begin
      step(0, 0, 1);
      n++;
    end
    chk("release_latency", n, 3);
    chk("release_level", 32'(wlvl), 15);
    chk("release_af", 32'(af), 1);
    rabs = 1;
    while (rabs < wabs) begin
      rabs++;
      step(0, 0, rabs);
    end
    any_full = 0; wrapped = 0;
    for (int i = 0; i < 40; i++) begin
      pg = wgray;
      if (rabs < wabs - 4) rabs++;
      step(1, 0, rabs);
      if (pg != wgray) chk("gray_1bit", $countones(pg ^ wgray), 1);
      if (pg == 5'b10000 && wgray == 5'b00000) wrapped = 1;
      if (full) any_full = 1;
    end
    chk("stream_wrap", wrapped, 1);
    chk("stream_no_full", any_full, 0);
    for (int i = 0; i < 300; i++) begin
      if (rabs < wabs && $urandom_range(0, 2) != 0) rabs++;
      step($urandom_range(0, 3) != 0 ? 1 : 0, $urandom_range(0, 7) == 0 ? 1 : 0, rabs);
    end
    step(1, 0, rabs);
    #1 rst_n = 0;
    #1;
    chk("midrst_outs", 32'({waddr, wgray, full, af, wlvl, ov}), 0);
    chk("midrst_weo", 32'(weo), 1);
    model_reset();
    we = 0; clr = 0; rg = '0;
    #1 rst_n = 1;
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    chk("sb_drain", sb.size(), 0);
    @(negedge clk) rst_n = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    we2 = 1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      chk("sweep_flags", 32'({af2, full2}), i == 8 ? 3 : 0);
    end
    chk("sweep_level", 32'(wlvl2), 8);
    we2 = 0; rg2 = 4'b0001;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (full2 && n < 10);
    chk("sweep_latency", n, 4);
    chk("sweep_level_after", 32'(wlvl2), 7);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_write_ctrl.md
# fifo_write_ctrl

Parametrised write-side controller for the dual-clock CDC FIFO. It owns the binary write pointer and its registered Gray copy, and synchronises the read-domain Gray pointer internally. It generates registered full, almost-full and fill-level flags, plus a sticky overflow error. It sits in the write clock domain between the producer and the dual-port memory; its Gray pointer goes to the read-side controller.

## Interface
Parameters:
- ADDR_W, 4: memory address width; DEPTH = 2**ADDR_W entries; pointers are ADDR_W+1 bits.
- SYNC_STAGES, 2: flop stages in the read-pointer synchroniser.
- AFULL_THRESH, DEPTH-2: fill level at or above which fifo_almost_full asserts.

Ports:
- write_clk  in  1  write-domain clock; all flops rising-edge.
- write_rst_n  in  1  asynchronous, active-low reset.
- write_enable_in  in  1  producer write request.
- overflow_clr  in  1  clears the sticky overflow flag.
- read_addr_gray_async  in  ADDR_W+1  read pointer (Gray) from the read domain, unsynchronised.
- write_addr  out  ADDR_W  binary memory write index (low bits of the write pointer).
- write_addr_gray  out  ADDR_W+1  registered Gray write pointer, to the read domain.
- write_enable_out  out  1  memory write strobe.
- fifo_full  out  1  registered full flag.
- fifo_almost_full  out  1  registered almost-full flag.
- write_level  out  ADDR_W+1  registered fill level, 0..DEPTH.
- overflow  out  1  sticky overflow error.

## Operation
- Internal pointer wptr[ADDR_W:0]; write_addr = wptr[ADDR_W-1:0].
- Accept: write_enable_out = write_enable_in & ~fifo_full. This is combinational, so the memory write happens on the same edge.
- wptr_next = wptr + accept. Wrap is modulo 2**(ADDR_W+1).
- Synchroniser: read_addr_gray_async passes through SYNC_STAGES flops to give rptr_gray_s, which is converted to binary rptr_s. Only the gray-to-binary conversion is combinational.
- level_next = wptr_next − rptr_s (modulo 2**(ADDR_W+1)).
- Registered on each edge: wptr←wptr_next; write_addr_gray←bin2gray(wptr_next); fifo_full←(level_next==DEPTH); fifo_almost_full←(level_next≥AFULL_THRESH); write_level←level_next.
- Overflow: set on any edge where write_enable_in=1 and fifo_full=1. Otherwise it is cleared on an edge where overflow_clr=1. If set and clear occur in the same cycle, set wins. The dropped write does not move the pointer.
- Full is pessimistic: the read pointer is seen SYNC_STAGES cycles late, so a free slot is never reported early.
- Elaboration errors: ADDR_W<2, SYNC_STAGES<2, AFULL_THRESH<1 or AFULL_THRESH>DEPTH.

## Timing
- Reset (async assert, sync-safe deassert handled upstream) forces every flop to 0. All outputs are then 0, including the synchroniser stages; write_enable_out = write_enable_in.
- Accepted write to visible pointer, gray pointer and level: 1 edge.
- The DEPTH-th unread accepted write asserts fifo_full on that same edge. The next request is dropped.
- A read-pointer change at the synchroniser input reaches fifo_full, write_level and fifo_almost_full after SYNC_STAGES+1 edges.
- A simultaneous accept and read advance is resolved by the arithmetic: the level is unchanged if both happen.
- Reset mid-operation: the pointer returns to 0 and overflow clears immediately, with no dependence on the clock.

## Structure
- Shared package cdc_fifo_pkg holds the functions bin2gray and gray2bin, both parametrised by width, and the default constants. The read-side controller reuses them.
- One sub-module, ptr_sync: an N-stage, WIDTH-bit synchroniser with async active-low reset, shared with the read side.
- Gray output comes straight from a flop, never from combinational logic.

## Test plan
- Reset with read pointer 0 → all outputs 0. Then hold write_enable_in=1 for 16 cycles (ADDR_W=4) → fifo_almost_full on the 14th edge and fifo_full on the 16th. At that point write_level=16, write_addr=0 and write_addr_gray=5'b11000.
- Full, then 3 more requests → write_enable_out=0, pointer stays 16, and overflow=1 from the first dropped request. overflow_clr pulse → overflow=0. overflow_clr asserted together with a drop → overflow stays 1.
- From full, drive read_addr_gray_async=5'b00001 → fifo_full falls after exactly 3 edges (SYNC_STAGES=2), write_level=15, and fifo_almost_full stays 1.
- Streaming: 40 writes with the read pointer trailing by 4 → the pointer wraps 31→0, write_addr_gray changes by exactly 1 bit per accept, and full never asserts.
- Assert write_rst_n=0 mid-stream, between clock edges → all outputs are 0 immediately. After release, the first write goes to write_addr=0.
- Parameter sweep ADDR_W=3, SYNC_STAGES=3, AFULL_THRESH=8 → almost-full and full assert together at level 8, and the read-to-flag latency is 4 edges.
